// File: rtl/mul_unit.sv
// mul_unit: 16x16 sequential shift-add multiplier.
// One start pulse latches the operands, sixteen CALC steps build the product,
// and the DONE state loads prod_hi/prod_lo and raises a one-cycle done pulse.
// Optional feature macro: MUL_SIGNED_EN (control_signal[23] selects
// two's-complement operation; without the macro bit 23 is ignored).
module mul_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] control_signal,
   input  logic [15:0] acc_in,
   input  logic [15:0] br_in,
   output logic [15:0] prod_hi,
   output logic [15:0] prod_lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] mcand;   // latched multiplicand
   logic [32:0] pp;      // {partial[32:16], multiplier[15:0]}, shifted right each step
   logic [4:0]  cnt;     // completed shift-add steps

   logic        start;
   logic        clear;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [16:0] sum;
   logic [31:0] result;

   assign start = control_signal[22];
   assign clear = control_signal[21];

`ifdef MUL_SIGNED_EN
   logic sgn_sel;
   logic op_neg;
   logic neg;            // result must be negated in DONE
   logic unused;

   assign sgn_sel = control_signal[23];
   // Signed operands are reduced to magnitudes at latch time; 0x8000 maps to
   // 0x8000, which is the correct unsigned magnitude.
   assign op_a    = (sgn_sel && acc_in[15]) ? (~acc_in + 16'd1) : acc_in;
   assign op_b    = (sgn_sel && br_in[15])  ? (~br_in + 16'd1)  : br_in;
   assign op_neg  = sgn_sel && (acc_in[15] ^ br_in[15]);
   assign result  = neg ? (~pp[31:0] + 32'd1) : pp[31:0];
   assign unused  = ^{control_signal[31:24], control_signal[20:0]};
`else
   logic unused;

   assign op_a   = acc_in;
   assign op_b   = br_in;
   assign result = pp[31:0];
   assign unused = ^{control_signal[31:23], control_signal[20:0]};
`endif

   // Shift-add datapath: add the multiplicand into the upper partial when the multiplier LSB is set.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path (here a single
      // unconditional assignment), so no latch can be inferred.
      sum = pp[32:16] + (pp[0] ? {1'b0, mcand} : 17'd0);
   end

   // Control FSM with registered outputs; operand latch, step counter and product registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!rst) begin
         // NOTE: every register, datapath included, is reset so an aborted
         // multiply leaves no residue behind.
         state   <= IDLE;
         mcand   <= 16'd0;
         pp      <= 33'd0;
         cnt     <= 5'd0;
         prod_hi <= 16'd0;
         prod_lo <= 16'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef MUL_SIGNED_EN
         neg     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  prod_hi <= 16'd0;
                  prod_lo <= 16'd0;
               end
               if (start) begin
                  mcand <= op_a;
                  pp    <= {17'd0, op_b};
                  cnt   <= 5'd0;
                  busy  <= 1'b1;
                  state <= CALC;
`ifdef MUL_SIGNED_EN
                  neg   <= op_neg;
`endif
               end
            end
            CALC: begin
               // Start and clear are both ignored while the core is running.
               pp  <= {1'b0, sum, pp[15:1]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd15) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // A clear arriving with the result load wins.
               if (clear) begin
                  prod_hi <= 16'd0;
                  prod_lo <= 16'd0;
               end else begin
                  prod_hi <= result[31:16];
                  prod_lo <= result[15:0];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
